// File: rtl/bus_master_port.sv
// Master-side bus port: converts one parallel command into the serial
// request / slave-select / address / data sequence expected by the arbiter.
module bus_master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [1:0]            cmd_slave,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  error,
  output logic                  bus_request,
  output logic                  bus_address_valid,
  output logic                  bus_address,
  output logic                  bus_data,
  output logic                  bus_valid,
  output logic                  bus_write_en,
  output logic                  bus_burst,
  input  logic                  bus_available,
  input  logic                  bus_ready,
  input  logic                  bus_data_in,
  input  logic                  bus_valid_in
);

  localparam int SW   = ADDR_WIDTH + 3;
  localparam int CMAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TMO_ZERO  = {TW{1'b0}};
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0, ST_REQ   = 4'd1, ST_SEL   = 4'd2,
    ST_CONN  = 4'd3, ST_ADDR  = 4'd4, ST_WDATA = 4'd5,
    ST_WACK  = 4'd6, ST_RWAIT = 4'd7, ST_REL   = 4'd8
  } state_t;

  state_t                state_r, next_s;
  logic [CW-1:0]         cnt_r, cnt_next_s;
  logic [TW-1:0]         tmo_r, tmo_next_s;
  logic                  done_next_s, error_next_s;
  logic                  write_r;
  logic [SW-1:0]         ash_r;
  logic [DATA_WIDTH-1:0] dsh_r, rd_data_r;
  logic                  req_next_s, av_next_s, valid_next_s, we_next_s;
  logic                  addr_bit_next_s, data_bit_next_s;
  logic                  done_r, error_r, req_r, av_r, valid_r, we_r, addr_bit_r, data_bit_r;

  assign cmd_ready         = (state_r == ST_IDLE);
  assign rd_data           = rd_data_r;
  assign done              = done_r;
  assign error             = error_r;
  assign bus_request       = req_r;
  assign bus_address_valid = av_r;
  assign bus_address       = addr_bit_r;
  assign bus_data          = data_bit_r;
  assign bus_valid         = valid_r;
  assign bus_write_en      = we_r;
  assign bus_burst         = 1'b0;

  // Next-state, phase counter and wait-state timeout decode
  always_comb begin
    next_s       = state_r;
    cnt_next_s   = cnt_r;
    tmo_next_s   = tmo_r;
    done_next_s  = 1'b0;
    error_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_next_s = CNT_ZERO;
        tmo_next_s = TMO_ZERO;
        if (cmd_start) begin
          if (cmd_slave == 2'd0) begin
            error_next_s = 1'b1;
            next_s       = ST_IDLE;
          end else begin
            next_s = ST_REQ;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      // cnt_r tracks consecutive cycles with the bus available
      ST_REQ: begin
        if (bus_available && (cnt_r == CNT_ONE)) begin
          next_s     = ST_SEL;
          cnt_next_s = CNT_ZERO;
        end else if (tmo_r == TMO_LAST) begin
          next_s       = ST_REL;
          error_next_s = 1'b1;
        end else begin
          cnt_next_s = bus_available ? CNT_ONE : CNT_ZERO;
          tmo_next_s = tmo_r + TMO_ONE;
        end
      end
      ST_SEL: begin
        if (cnt_r == CNT_TWO) begin
          next_s     = ST_CONN;
          cnt_next_s = CNT_ZERO;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_CONN: begin
        if (cnt_r == CNT_ONE) begin
          next_s     = ST_ADDR;
          cnt_next_s = CNT_ZERO;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_ADDR: begin
        if (cnt_r == ADDR_LAST) begin
          next_s     = write_r ? ST_WDATA : ST_RWAIT;
          cnt_next_s = CNT_ZERO;
          tmo_next_s = TMO_ZERO;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_WDATA: begin
        if (cnt_r == DATA_LAST) begin
          next_s     = ST_WACK;
          cnt_next_s = CNT_ZERO;
          tmo_next_s = TMO_ZERO;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_WACK: begin
        if (bus_ready) begin
          next_s      = ST_REL;
          done_next_s = 1'b1;
        end else if (tmo_r == TMO_LAST) begin
          next_s       = ST_REL;
          error_next_s = 1'b1;
        end else begin
          tmo_next_s = tmo_r + TMO_ONE;
        end
      end
      // a final bit arriving on the last allowed cycle still completes
      ST_RWAIT: begin
        if (bus_valid_in && (cnt_r == DATA_LAST)) begin
          next_s      = ST_REL;
          done_next_s = 1'b1;
        end else if (tmo_r == TMO_LAST) begin
          next_s       = ST_REL;
          error_next_s = 1'b1;
        end else begin
          tmo_next_s = tmo_r + TMO_ONE;
          if (bus_valid_in) begin
            cnt_next_s = cnt_r + CNT_ONE;
          end else begin
            cnt_next_s = cnt_r;
          end
        end
      end
      ST_REL:  next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // Bus outputs for the upcoming state, registered below
  always_comb begin
    req_next_s      = 1'b0;
    av_next_s       = 1'b0;
    valid_next_s    = 1'b0;
    we_next_s       = 1'b0;
    addr_bit_next_s = 1'b0;
    data_bit_next_s = 1'b0;
    case (next_s)
      ST_REQ: begin
        req_next_s = 1'b1;
        av_next_s  = 1'b1;
      end
      ST_SEL: begin
        req_next_s      = 1'b1;
        valid_next_s    = 1'b1;
        addr_bit_next_s = ash_r[SW-1];
      end
      ST_CONN: req_next_s = 1'b1;
      ST_ADDR: begin
        req_next_s      = 1'b1;
        valid_next_s    = 1'b1;
        addr_bit_next_s = ash_r[SW-1];
        we_next_s       = write_r;
      end
      ST_WDATA: begin
        req_next_s      = 1'b1;
        valid_next_s    = 1'b1;
        data_bit_next_s = dsh_r[DATA_WIDTH-1];
        we_next_s       = write_r;
      end
      ST_WACK, ST_RWAIT: begin
        req_next_s = 1'b1;
        we_next_s  = write_r;
      end
      default: req_next_s = 1'b0;
    endcase
  end

  // State, counters, command latch and serial shift registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      tmo_r     <= TMO_ZERO;
      write_r   <= 1'b0;
      ash_r     <= {SW{1'b0}};
      dsh_r     <= {DATA_WIDTH{1'b0}};
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= next_s;
      cnt_r   <= cnt_next_s;
      tmo_r   <= tmo_next_s;
      if ((state_r == ST_IDLE) && cmd_start) begin
        write_r <= cmd_write;
        ash_r   <= {cmd_slave[1], cmd_slave[1], cmd_slave[0], cmd_addr};
        dsh_r   <= cmd_wdata;
      end else begin
        if ((next_s == ST_SEL) || (next_s == ST_ADDR)) begin
          ash_r <= {ash_r[SW-2:0], 1'b0};
        end
        if (next_s == ST_WDATA) begin
          dsh_r <= {dsh_r[DATA_WIDTH-2:0], 1'b0};
        end
      end
      if ((state_r == ST_RWAIT) && bus_valid_in) begin
        rd_data_r <= {rd_data_r[DATA_WIDTH-2:0], bus_data_in};
      end
    end
  end

  // Registered status and bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      req_r      <= 1'b0;
      av_r       <= 1'b0;
      valid_r    <= 1'b0;
      we_r       <= 1'b0;
      addr_bit_r <= 1'b0;
      data_bit_r <= 1'b0;
    end else begin
      done_r     <= done_next_s;
      error_r    <= error_next_s;
      req_r      <= req_next_s;
      av_r       <= av_next_s;
      valid_r    <= valid_next_s;
      we_r       <= we_next_s;
      addr_bit_r <= addr_bit_next_s;
      data_bit_r <= data_bit_next_s;
    end
  end

endmodule
